memory_arbiter: RTL and testbench

//  Shares the single-port word-addressed main memory between the instruction-fetch

---
 rtl/memory_pkg.sv | 36 +++
 rtl/arb_starve_guard.sv | 48 ++++
 rtl/memory_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module  : memory_pkg
// Purpose : Shared constants, response-owner encoding, tag record and the
//           address range helper for the memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package memory_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MEM_WORDS  = 1024;
  localparam int unsigned MAX_WAIT   = 4;

  // Which port a pipelined read/ack belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Bookkeeping that travels alongside an issued request.
  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   load;
    logic   error;
  } tag_t;

  // True when a word address falls inside the populated memory.
  function automatic logic in_range(input logic [63:0] addr, input int unsigned words);
    return addr < 64'(words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_starve_guard.sv
`default_nettype none
// ============================================================================
// Module  : arb_starve_guard
// Purpose : Picks one of the fetch/data requesters per cycle. Data wins by
//           default; a fetch that has lost MAX_WAIT times in a row wins next.
// Rev     : 1.0  initial release
// ============================================================================
module arb_starve_guard #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic if_req_valid,
  input  logic d_req_valid,
  output logic grant_if,
  output logic grant_d
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             starved;

  // Grant select and starvation counter update.
  always_comb begin
    starved    = (wait_cnt_q >= CNT_W'(MAX_WAIT));
    grant_if   = if_req_valid & (~d_req_valid | starved);
    grant_d    = d_req_valid & ~grant_if;
    wait_cnt_d = wait_cnt_q;
    if (!if_req_valid || grant_if) begin
      wait_cnt_d = '0;
    end else if (!starved) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : memory_arbiter
// Purpose : Shares a single-port synchronous memory between instruction fetch
//           and the load/store port. Memory controls come from registers; a
//           two-stage tag pipe routes each response to its owner.
// Rev     : 1.0  initial release
// ============================================================================
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = memory_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = memory_pkg::DATA_WIDTH,
  parameter int unsigned MEM_WORDS  = memory_pkg::MEM_WORDS,
  parameter int unsigned MAX_WAIT   = memory_pkg::MAX_WAIT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  output logic                  if_rsp_error,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_write,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  d_rsp_error,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_value,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_value
);

  logic grant_if;
  logic grant_d;

  arb_starve_guard #(
    .MAX_WAIT (MAX_WAIT)
  ) u_guard (
    .clock        (clock),
    .reset_n      (reset_n),
    .if_req_valid (if_req_valid),
    .d_req_valid  (d_req_valid),
    .grant_if     (grant_if),
    .grant_d      (grant_d)
  );

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  logic                  re_q,    re_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  we_q,    we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wval_q,  wval_d;
  tag_t                  tag1_q,  tag1_d;
  tag_t                  tag2_q,  tag2_d;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_ok;
  logic                  sel_write;
  logic                  accept;

  // Issue stage: register memory controls for the granted request.
  always_comb begin
    sel_addr  = grant_if ? if_req_addr : d_req_addr;
    sel_ok    = in_range(64'(sel_addr), MEM_WORDS);
    sel_write = grant_d & d_req_write;
    accept    = grant_if | grant_d;
    re_d      = 1'b0;
    raddr_d   = '0;
    we_d      = 1'b0;
    waddr_d   = '0;
    wval_d    = '0;
    tag1_d    = '0;
    tag2_d    = tag1_q;
    if (accept) begin
      tag1_d.valid = 1'b1;
      tag1_d.owner = grant_if ? OWN_IF : OWN_D;
      tag1_d.load  = ~sel_write;
      tag1_d.error = ~sel_ok;
      if (sel_ok) begin
        if (sel_write) begin
          we_d    = 1'b1;
          waddr_d = sel_addr;
          wval_d  = d_req_wdata;
        end else begin
          re_d    = 1'b1;
          raddr_d = sel_addr;
        end
      end
    end
  end

  // Issue registers and tag pipe; reset drops anything in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      re_q    <= 1'b0;
      raddr_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wval_q  <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
    end else begin
      re_q    <= re_d;
      raddr_q <= raddr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wval_q  <= wval_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
    end
  end

  assign mem_read_enable   = re_q;
  assign mem_read_address  = raddr_q;
  assign mem_write_enable  = we_q;
  assign mem_write_address = waddr_q;
  assign mem_write_value   = wval_q;

  logic [DATA_WIDTH-1:0] rsp_data;

  // Response routing; memory data only passes for a valid in-range load so a
  // floating read bus never reaches the requesters.
  always_comb begin
    rsp_data     = '0;
    if (tag2_q.valid && tag2_q.load && !tag2_q.error) begin
      rsp_data = mem_read_value;
    end
    if_rsp_valid = tag2_q.valid && (tag2_q.owner == OWN_IF);
    d_rsp_valid  = tag2_q.valid && (tag2_q.owner == OWN_D);
    if_rsp_data  = if_rsp_valid ? rsp_data : '0;
    d_rsp_data   = d_rsp_valid  ? rsp_data : '0;
    if_rsp_error = if_rsp_valid & tag2_q.error;
    d_rsp_error  = d_rsp_valid  & tag2_q.error;
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_arbiter
// Purpose : Directed cycle-by-cycle vectors for memory_arbiter with a small
//           synchronous memory model, plus store-path and reset sequences.
// Rev     : 1.0  initial release
// ============================================================================
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_error;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_write;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_error;
  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_value;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_value;

  memory_arbiter dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .if_req_valid      (if_req_valid),
    .if_req_ready      (if_req_ready),
    .if_req_addr       (if_req_addr),
    .if_rsp_valid      (if_rsp_valid),
    .if_rsp_data       (if_rsp_data),
    .if_rsp_error      (if_rsp_error),
    .d_req_valid       (d_req_valid),
    .d_req_ready       (d_req_ready),
    .d_req_write       (d_req_write),
    .d_req_addr        (d_req_addr),
    .d_req_wdata       (d_req_wdata),
    .d_rsp_valid       (d_rsp_valid),
    .d_rsp_data        (d_rsp_data),
    .d_rsp_error       (d_rsp_error),
    .mem_read_enable   (mem_read_enable),
    .mem_read_address  (mem_read_address),
    .mem_read_value    (mem_read_value),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_value   (mem_write_value)
  );

  always #5 clock = ~clock;

  // Unwritten memory words hold a fixed image: 0xC0DE in the top half,
  // the word index in the bottom half.
  function automatic logic [31:0] img(input int unsigned idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  logic [31:0] mem_store [0:1023];
  logic        mem_written [0:1023];

  // Synchronous single-port memory model; read bus floats when not enabled.
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 1024; k++) mem_written[k] <= 1'b0;
    end else if (mem_write_enable) begin
      mem_store[mem_write_address[9:0]]   <= mem_write_value;
      mem_written[mem_write_address[9:0]] <= 1'b1;
    end
    if (mem_read_enable) begin
      mem_read_value <= mem_written[mem_read_address[9:0]] ?
                        mem_store[mem_read_address[9:0]] : img(mem_read_address[9:0]);
    end else begin
      mem_read_value <= 'z;
    end
  end

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        dw;
    logic [31:0] da;
    logic [31:0] wd;
    logic        e_ir;
    logic        e_dr;
    logic        e_iv;
    logic [31:0] e_id;
    logic        e_ie;
    logic        e_dv;
    logic [31:0] e_dd;
    logic        e_de;
    logic        e_re;
    logic        e_we;
  } vec_t;

  vec_t tbl [$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(
    input logic iv, input logic [31:0] ia,
    input logic dv, input logic dw, input logic [31:0] da, input logic [31:0] wd,
    input logic e_ir, input logic e_dr,
    input logic e_iv, input logic [31:0] e_id, input logic e_ie,
    input logic e_dv, input logic [31:0] e_dd, input logic e_de,
    input logic e_re, input logic e_we);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.dw = dw; v.da = da; v.wd = wd;
    v.e_ir = e_ir; v.e_dr = e_dr;
    v.e_iv = e_iv; v.e_id = e_id; v.e_ie = e_ie;
    v.e_dv = e_dv; v.e_dd = e_dd; v.e_de = e_de;
    v.e_re = e_re; v.e_we = e_we;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic dw, input logic [31:0] da, input logic [31:0] wd);
    if_req_valid = iv;
    if_req_addr  = ia;
    d_req_valid  = dv;
    d_req_write  = dw;
    d_req_addr   = da;
    d_req_wdata  = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " if_req_ready"},  32'(if_req_ready), 32'd0);
    check({tag, " d_req_ready"},   32'(d_req_ready), 32'd0);
    check({tag, " if_rsp_valid"},  32'(if_rsp_valid), 32'd0);
    check({tag, " if_rsp_data"},   if_rsp_data, 32'd0);
    check({tag, " d_rsp_valid"},   32'(d_rsp_valid), 32'd0);
    check({tag, " d_rsp_data"},    d_rsp_data, 32'd0);
    check({tag, " mem_re"},        32'(mem_read_enable), 32'd0);
    check({tag, " mem_raddr"},     mem_read_address, 32'd0);
    check({tag, " mem_we"},        32'(mem_write_enable), 32'd0);
  endtask

  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Row columns: iv ia | dv dw da wd | if_rdy d_rdy | if_rsp v/data/err | d_rsp v/data/err | mem_re mem_we
    // Fetch-only burst, addresses 0..3, then drain.
    tbl.push_back(mk(1, 0, 0,0,0,0, 1,0, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(1, 1, 0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,0));
    tbl.push_back(mk(1, 2, 0,0,0,0, 1,0, 1,img(0),0, 0,0,0, 1,0));
    tbl.push_back(mk(1, 3, 0,0,0,0, 1,0, 1,img(1),0, 0,0,0, 1,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 1,img(2),0, 0,0,0, 1,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 1,img(3),0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0));
    // Contention for six cycles: data wins four, fetch the fifth, data again.
    tbl.push_back(mk(1, 4, 1,0,8,0, 0,1, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(1, 4, 1,0,8,0, 0,1, 0,0,0, 0,0,0, 1,0));
    tbl.push_back(mk(1, 4, 1,0,8,0, 0,1, 0,0,0, 1,img(8),0, 1,0));
    tbl.push_back(mk(1, 4, 1,0,8,0, 0,1, 0,0,0, 1,img(8),0, 1,0));
    tbl.push_back(mk(1, 4, 1,0,8,0, 1,0, 0,0,0, 1,img(8),0, 1,0));
    tbl.push_back(mk(1, 4, 1,0,8,0, 0,1, 0,0,0, 1,img(8),0, 1,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 1,img(4),0, 0,0,0, 1,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 0,0,0, 1,img(8),0, 0,0));
    // Store then immediate load of the same word.
    tbl.push_back(mk(0, 0, 1,1,32'h10,BEEF, 0,1, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 0, 1,0,32'h10,0,    0,1, 0,0,0, 0,0,0, 0,1));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 0,0,0, 1,0,0,    1,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 0,0,0, 1,BEEF,0, 0,0));
    // Out-of-range load at exactly MEM_WORDS, then an out-of-range fetch.
    tbl.push_back(mk(0, 0, 1,0,32'd1024,0, 0,1, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 0,0,0, 1,0,1, 0,0));
    tbl.push_back(mk(1, 32'd2000, 0,0,0,0, 1,0, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 1,0,1, 0,0,0, 0,0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0));

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Table-driven cycles.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].ia, tbl[i].dv, tbl[i].dw, tbl[i].da, tbl[i].wd);
      @(negedge clock);
      check($sformatf("v%0d if_req_ready", i), 32'(if_req_ready), 32'(tbl[i].e_ir));
      check($sformatf("v%0d d_req_ready", i),  32'(d_req_ready),  32'(tbl[i].e_dr));
      check($sformatf("v%0d if_rsp_valid", i), 32'(if_rsp_valid), 32'(tbl[i].e_iv));
      check($sformatf("v%0d if_rsp_data", i),  if_rsp_data,       tbl[i].e_id);
      check($sformatf("v%0d if_rsp_error", i), 32'(if_rsp_error), 32'(tbl[i].e_ie));
      check($sformatf("v%0d d_rsp_valid", i),  32'(d_rsp_valid),  32'(tbl[i].e_dv));
      check($sformatf("v%0d d_rsp_data", i),   d_rsp_data,        tbl[i].e_dd);
      check($sformatf("v%0d d_rsp_error", i),  32'(d_rsp_error),  32'(tbl[i].e_de));
      check($sformatf("v%0d mem_re", i),       32'(mem_read_enable),  32'(tbl[i].e_re));
      check($sformatf("v%0d mem_we", i),       32'(mem_write_enable), 32'(tbl[i].e_we));
      @(posedge clock);
      #1;
    end

    // Store path drives address and data from registers.
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'h1234_5678);
    @(posedge clock);
    #1 drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd7, 32'd0);
    @(negedge clock);
    check("st mem_we",    32'(mem_write_enable), 32'd1);
    check("st mem_waddr", mem_write_address, 32'd5);
    check("st mem_wval",  mem_write_value, 32'h1234_5678);
    check("st mem_re",    32'(mem_read_enable), 32'd0);
    @(posedge clock);
    #1 drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("ld mem_re",    32'(mem_read_enable), 32'd1);
    check("ld mem_raddr", mem_read_address, 32'd7);
    check("ld mem_we",    32'(mem_write_enable), 32'd0);
    repeat (3) @(posedge clock);
    #1;

    // Reset with two fetches in flight: nothing may come back.
    drive(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clock);
    #1 drive(1'b1, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0);
    reset_n = 1'b0;
    @(posedge clock);
    #1 drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check_all_zero("rst1");
    check("rst1 if_rsp_error", 32'(if_rsp_error), 32'd0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      check($sformatf("rst%0d if_rsp_valid", j + 2), 32'(if_rsp_valid), 32'd0);
      check($sformatf("rst%0d if_rsp_data", j + 2),  if_rsp_data, 32'd0);
      check($sformatf("rst%0d mem_re", j + 2),       32'(mem_read_enable), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
